// File: rtl/fp_normalizer_pkg.sv
// Shared types and constants for the floating-point mantissa normalizer.
package fp_normalizer_pkg;

  localparam int MANT_W  = 24;
  localparam int EXP_W   = 8;
  localparam int EXP_MAX = 255;

  localparam int K16 = 16;
  localparam int K8  = 8;
  localparam int K4  = 4;
  localparam int K2  = 2;
  localparam int K1  = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CARRY = 3'd1,
    S16   = 3'd2,
    S8    = 3'd3,
    S4    = 3'd4,
    S2    = 3'd5,
    S1    = 3'd6,
    DONE  = 3'd7
  } state_t;

  // Shift amount of the stage at position idx in the S16..S1 sequence.
  function automatic int stage_amt(input int idx);
    case (idx)
      0:       stage_amt = K16;
      1:       stage_amt = K8;
      2:       stage_amt = K4;
      3:       stage_amt = K2;
      default: stage_amt = K1;
    endcase
  endfunction

endpackage

// File: rtl/fp_normalizer_norm_stage.sv
// One normalization step: shift left by K when the top K mantissa bits are
// clear and the exponent can absorb it without reaching the floor.
module norm_stage #(
  parameter int K = 1
) (
  input  logic        en,
  input  logic [24:0] m,
  input  logic [8:0]  e,
  output logic [24:0] m_out,
  output logic [8:0]  e_out,
  output logic [4:0]  sh_add
);

  logic hit;

  assign hit    = en && (m[23 -: K] == '0) && (e > 9'(K));
  assign m_out  = hit ? (m << K) : m;
  assign e_out  = hit ? (e - 9'(K)) : e;
  assign sh_add = hit ? 5'(K) : 5'd0;

endmodule

// File: rtl/fp_normalizer.sv
// Multi-cycle normalizer for an adder mantissa sum: carry fix-up, then a
// 16/8/4/2/1 leading-zero shift sequence, result held until consumed.
module fp_normalizer
  import fp_normalizer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic [24:0] In,
  input  logic [7:0]  Exp_in,
  output logic        Out_valid,
  input  logic        Out_ready,
  output logic [23:0] Out,
  output logic [7:0]  Exp_out,
  output logic [4:0]  Shift,
  output logic        Zero,
  output logic        Overflow,
  output logic        Underflow,
  output logic [2:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds its payload stable until that edge.

  state_t      state_q, state_d;
  logic [24:0] m_q, m_d;
  logic [8:0]  e_q, e_d, e_inc;
  logic [4:0]  sh_q, sh_d;
  logic        ovf_q, ovf_d;
  logic [23:0] out_q, out_d;
  logic [7:0]  eo_q, eo_d;
  logic [4:0]  so_q, so_d;
  logic        zero_q, zero_d;
  logic        ovo_q, ovo_d;
  logic        udf_q, udf_d;

  logic [24:0] st_m  [5];
  logic [8:0]  st_e  [5];
  logic [4:0]  st_sh [5];
  logic [2:0]  sidx;

  // A saturated result must keep its 255 exponent, so stages stay idle.
  for (genvar i = 0; i < 5; i++) begin : g_stage
    norm_stage #(.K(stage_amt(i))) u_stage (
      .en     (!ovf_q),
      .m      (m_q),
      .e      (e_q),
      .m_out  (st_m[i]),
      .e_out  (st_e[i]),
      .sh_add (st_sh[i])
    );
  end

  always_comb begin
    sidx = 3'd0;
    case (state_q)
      S8:      sidx = 3'd1;
      S4:      sidx = 3'd2;
      S2:      sidx = 3'd3;
      S1:      sidx = 3'd4;
      default: sidx = 3'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    sh_d    = sh_q;
    ovf_d   = ovf_q;
    out_d   = out_q;
    eo_d    = eo_q;
    so_d    = so_q;
    zero_d  = zero_q;
    ovo_d   = ovo_q;
    udf_d   = udf_q;
    e_inc   = e_q + 9'd1;
    case (state_q)
      IDLE: begin
        if (In_valid) begin
          m_d     = In;
          e_d     = {1'b0, Exp_in};
          sh_d    = 5'd0;
          ovf_d   = 1'b0;
          state_d = CARRY;
        end
      end
      CARRY: begin
        if (m_q[24]) begin
          if (e_inc >= 9'(EXP_MAX)) begin
            ovf_d = 1'b1;
            m_d   = '0;
            e_d   = 9'(EXP_MAX);
          end else begin
            m_d = m_q >> 1;
            e_d = e_inc;
          end
        end
        state_d = S16;
      end
      S16, S8, S4, S2: begin
        m_d  = st_m[sidx];
        e_d  = st_e[sidx];
        sh_d = sh_q + st_sh[sidx];
        case (state_q)
          S16:     state_d = S8;
          S8:      state_d = S4;
          S4:      state_d = S2;
          default: state_d = S1;
        endcase
      end
      S1: begin
        m_d    = st_m[4];
        e_d    = st_e[4];
        sh_d   = sh_q + st_sh[4];
        out_d  = st_m[4][23:0];
        eo_d   = st_e[4][7:0];
        so_d   = sh_q + st_sh[4];
        zero_d = 1'b0;
        ovo_d  = ovf_q;
        udf_d  = 1'b0;
        if (st_m[4][23:0] == '0 && !ovf_q) begin
          out_d  = '0;
          eo_d   = '0;
          so_d   = '0;
          zero_d = 1'b1;
        end else if (st_m[4][23:0] != '0 && !st_m[4][23]) begin
          eo_d  = '0;
          udf_d = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        if (Out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      sh_q    <= '0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
      eo_q    <= '0;
      so_q    <= '0;
      zero_q  <= 1'b0;
      ovo_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      sh_q    <= sh_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
      eo_q    <= eo_d;
      so_q    <= so_d;
      zero_q  <= zero_d;
      ovo_q   <= ovo_d;
      udf_q   <= udf_d;
    end
  end

  assign In_ready  = (state_q == IDLE);
  assign Out_valid = (state_q == DONE);
  assign Out       = out_q;
  assign Exp_out   = eo_q;
  assign Shift     = so_q;
  assign Zero      = zero_q;
  assign Overflow  = ovo_q;
  assign Underflow = udf_q;
  assign dbg_state = state_q;

endmodule
